// File: rtl/uart_byte_rx_if.sv
// UART byte receiver port bundle.
// The line side and the byte/strobe side share one interface.
interface uart_byte_rx_if;
  logic       uart_rx;
  logic [2:0] baud_set;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  modport master (
    output uart_rx,
    output baud_set,
    input  data,
    input  rx_done,
    input  frame_err,
    input  uart_state
  );

  modport slave (
    input  uart_rx,
    input  baud_set,
    output data,
    output rx_done,
    output frame_err,
    output uart_state
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver, 16x oversampled, 3-sample majority vote.
// Pairs with the UART byte transmitter; same baud_set encoding.
module uart_byte_rx #(
  parameter int   SYNC_STAGES = 2,
  parameter logic START_BIT   = 1'b0,
  parameter logic STOP_BIT    = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  uart_byte_rx_if.slave rx
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_prev;
  logic       synced;
  logic       fall;

  logic [8:0] div_sel;
  logic [8:0] div_q;
  logic [8:0] presc;
  logic       tick;
  logic [3:0] tick_idx;
  logic [2:0] bit_idx;

  logic       s7;
  logic       s8;
  logic       maj;
  logic       mid;
  logic       last;

  logic [7:0] shreg;
  logic [7:0] data_q;
  logic       done_q;
  logic       ferr_q;
  logic       busy_q;

  assign synced = sync_q[SYNC_STAGES-1];
  assign fall   = rx_prev & ~synced;

  assign tick = (state != IDLE) && (presc == div_q);
  assign mid  = tick && (tick_idx == 4'd9);
  assign last = tick && (tick_idx == 4'd15);

  // third sample is the live line on the tick-9 cycle
  assign maj = (s7 & s8) | (s7 & synced) | (s8 & synced);

  assign rx.data       = data_q;
  assign rx.rx_done    = done_q;
  assign rx.frame_err  = ferr_q;
  assign rx.uart_state = busy_q;

  always_comb begin
    div_sel = 9'd325;
    unique case (rx.baud_set)
      3'd0:    div_sel = 9'd325;
      3'd1:    div_sel = 9'd162;
      3'd2:    div_sel = 9'd80;
      3'd3:    div_sel = 9'd53;
      3'd4:    div_sel = 9'd26;
      default: div_sel = 9'd325;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx.uart_rx};
      rx_prev <= synced;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      div_q    <= '0;
      presc    <= '0;
      tick_idx <= '0;
      bit_idx  <= '0;
      s7       <= 1'b0;
      s8       <= 1'b0;
      shreg    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;

      if (state != IDLE) begin
        presc <= tick ? '0 : presc + 9'd1;
      end

      if (tick) begin
        tick_idx <= tick_idx + 4'd1;
        if (tick_idx == 4'd7) s7 <= synced;
        if (tick_idx == 4'd8) s8 <= synced;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            busy_q   <= 1'b1;
            div_q    <= div_sel;
            presc    <= '0;
            tick_idx <= '0;
            bit_idx  <= '0;
          end
        end

        START: begin
          if (mid && (maj != START_BIT)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (last) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (mid) begin
            shreg <= {maj, shreg[7:1]};
          end
          if (last) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end

        STOP: begin
          // return early so a back-to-back start edge is not missed
          if (mid) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (maj == STOP_BIT) begin
              data_q <= shreg;
              done_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx.
// Frames are driven bit by bit; a negedge monitor records pulses.
module tb_uart_byte_rx;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #10 clk = ~clk;

  uart_byte_rx_if u_if ();

  uart_byte_rx dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (u_if.slave)
  );

  int tests = 0;
  int fails = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int run      = 0;
  int last_run = 0;
  int unsigned t_done = 0;
  int unsigned t_fall = 0;
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] dq[$];

  always @(negedge clk) begin
    if (u_if.rx_done) begin
      done_cnt++;
      t_done = cyc;
      dq.push_back(u_if.data);
    end
    if (u_if.frame_err) ferr_cnt++;
    if (u_if.rx_done && u_if.frame_err) both_cnt++;
    if ((u_if.rx_done && prev_done) || (u_if.frame_err && prev_ferr))
      wide_cnt++;
    prev_done = u_if.rx_done;
    prev_ferr = u_if.frame_err;
    if (u_if.uart_state) begin
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic lvl, input int bclk, input bit gl);
    for (int i = 0; i < bclk; i++) begin
      u_if.uart_rx = (gl && i >= 240 && i <= 248) ? ~lvl : lvl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int div,
                            input logic stop_lvl, input bit gl,
                            input bit chg, input logic [2:0] nb);
    int bclk;
    bclk = 16 * (div + 1);
    t_fall = cyc;
    drive_bit(1'b0, bclk, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (chg && i == 4) u_if.baud_set = nb;
      drive_bit(b[i], bclk, gl);
    end
    drive_bit(stop_lvl, bclk, 1'b0);
  endtask

  int lat;

  initial begin
    u_if.uart_rx  = 1'b1;
    u_if.baud_set = 3'd4;
    #5 rstn = 1'b0;
    #20;
    chk("rst_data", u_if.data, 8'h00);
    chk("rst_done", u_if.rx_done, 1'b0);
    chk("rst_ferr", u_if.frame_err, 1'b0);
    chk("rst_state", u_if.uart_state, 1'b0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 115200, 0xA5
    send_frame(8'hA5, 26, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("a5_cnt", done_cnt, 1);
    chk("a5_data", u_if.data, 8'hA5);
    chk("a5_ferr", ferr_cnt, 0);
    chk("a5_state", u_if.uart_state, 1'b0);
    chk("a5_busy_len", last_run, 154 * 27);
    lat = int'(t_done - t_fall);
    tests++;
    assert (lat >= 4161 && lat <= 4163) else begin
      fails++;
      $error("FAIL a5_latency: observed %0d expected 4162 +/-1", lat);
    end

    // 57600 back-to-back
    u_if.baud_set = 3'd3;
    send_frame(8'h00, 53, 1'b1, 1'b0, 1'b0, 3'd0);
    send_frame(8'hFF, 53, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_cnt", done_cnt, 3);
    chk("b2b_first", dq[1], 8'h00);
    chk("b2b_second", dq[2], 8'hFF);
    chk("b2b_busy_len", last_run, 154 * 54);

    // framing error then break
    u_if.baud_set = 3'd4;
    send_frame(8'h3C, 26, 1'b0, 1'b0, 1'b0, 3'd0);
    drive_bit(1'b0, 432 * 19, 1'b0);
    chk("ferr_cnt", ferr_cnt, 1);
    chk("ferr_nodone", done_cnt, 3);
    chk("ferr_data", u_if.data, 8'hFF);
    chk("break_idle", u_if.uart_state, 1'b0);
    drive_bit(1'b1, 864, 1'b0);
    send_frame(8'h81, 26, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("brk_cnt", done_cnt, 4);
    chk("brk_data", u_if.data, 8'h81);

    // false starts at 38400 and 9600
    u_if.baud_set = 3'd2;
    drive_bit(1'b0, 4 * 81, 1'b0);
    drive_bit(1'b1, 2000, 1'b0);
    chk("fs2_busy_len", last_run, 10 * 81);
    chk("fs2_nodone", done_cnt, 4);
    chk("fs2_noferr", ferr_cnt, 1);
    u_if.baud_set = 3'd0;
    drive_bit(1'b0, 100, 1'b0);
    drive_bit(1'b1, 4000, 1'b0);
    chk("fs0_busy_len", last_run, 10 * 326);
    chk("fs0_nodone", done_cnt, 4);
    u_if.baud_set = 3'd4;
    send_frame(8'h5A, 26, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("fs_next_cnt", done_cnt, 5);
    chk("fs_next_data", u_if.data, 8'h5A);

    // glitch on every data bit's middle sample
    send_frame(8'hC3, 26, 1'b1, 1'b1, 1'b0, 3'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("gl_cnt", done_cnt, 6);
    chk("gl_data", u_if.data, 8'hC3);

    // reset mid-frame
    drive_bit(1'b0, 432, 1'b0);
    drive_bit(1'b1, 432 * 3, 1'b0);
    drive_bit(1'b0, 200, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mrst_data", u_if.data, 8'h00);
    chk("mrst_state", u_if.uart_state, 1'b0);
    chk("mrst_done", u_if.rx_done, 1'b0);
    chk("mrst_ferr", u_if.frame_err, 1'b0);
    u_if.uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_nodone", done_cnt, 6);
    send_frame(8'h7E, 26, 1'b1, 1'b0, 1'b1, 3'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("baudchg_cnt", done_cnt, 7);
    chk("baudchg_data", u_if.data, 8'h7E);
    u_if.baud_set = 3'd4;

    chk("never_both", both_cnt, 0);
    chk("pulse_width", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
